decode_sequencer: RTL
=====================

Name: decode_sequencer

Overview:
- Sequences the combinational 192-bit line decoder (decodeMessage) across a stored encoded message.
- Fetches each 192-bit encoded line from a synchronous line memory and drives it into the decoder.
- Captures the 24-character recovered line and streams it out one ASCII byte per handshake.
- Sits between the encoded-text ROM/RAM and a character sink (display or UART), replacing bench-driven looping in hardware.

Parameters:
- NUM_MESSAGES, 8, number of 192-bit lines to decode per run.
- ADDR_W, 3, line memory address width; must satisfy 2**ADDR_W >= NUM_MESSAGES.
- LINE_W, 192, line width in bits; must be a multiple of 8.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse when the run completes.
- mem_rd_en  out  1  read strobe to line memory.
- mem_addr  out  ADDR_W  line index being read.
- mem_rdata  in  LINE_W  read data; valid exactly 1 cycle after mem_rd_en.
- dec_in  out  LINE_W  registered line driven to decoder input.
- dec_out  in  LINE_W  decoder output (combinational from dec_in).
- char_valid  out  1  output byte valid.
- char_data  out  8  current ASCII byte.
- char_last  out  1  high with the final byte of the final line.
- char_ready  in  1  sink accepts when char_valid && char_ready at a rising edge.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - busy=0, done=0, mem_rd_en=0, mem_addr=0, dec_in=0.
  - char_valid=0, char_data=0, char_last=0.
  - line_idx=0, byte_cnt=0, capture buffer=0.
  - Reset mid-run aborts immediately; no partial output resumes.
- FSM states and transitions:
  - IDLE: if start, set line_idx=0 -> FETCH.
  - FETCH: mem_rd_en=1, mem_addr=line_idx -> WAIT.
  - WAIT: mem_rdata valid; register dec_in<=mem_rdata -> LATCH.
  - LATCH: dec_in stable for a full cycle; buf<=dec_out, byte_cnt<=0 -> EMIT.
  - EMIT: char_valid=1, char_data=buf[LINE_W-1 -: 8], MSB byte first, matching %s print order.
    - On handshake: buf<<=8, byte_cnt++.
    - On handshake of byte LINE_W/8-1: last line -> DONE; otherwise line_idx++ -> FETCH.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- char_data and char_valid are registered.
- char_valid stays high and char_data stays stable until accepted; no retraction.
- char_last=1 only when line_idx==NUM_MESSAGES-1 and byte_cnt==LINE_W/8-1.
- start while busy is ignored; start held high through DONE begins a new run from IDLE on the next cycle.
- Latency: start sampled at edge E0; mem_rd_en high after E0; first char_valid high after E3.
- Per line with char_ready=1: 3 overhead + 24 byte cycles = 27 cycles. Full default run = 216 cycles from start to done.
- NUL bytes (0x00) are emitted like any other byte; no filtering.
- line_idx never exceeds NUM_MESSAGES-1; mem_addr does not wrap within a run.

Test Plan:
- Bench uses a stub decoder (dec_out = dec_in). Line k = 24 bytes of 8'h41+k. Pulse start, char_ready=1 -> 192 bytes: 24x'A', then 24x'B', ... 24x'H'. char_last only on the 192nd byte; done pulses once, 216 cycles after start; busy low afterwards.
- Line 0 = "Hello, World!" padded with 0x20 to 24 bytes; line order check -> char_data sequence 'H','e','l','l','o',... with first byte taken from bits [191:184].
- Backpressure: char_ready toggles 1,0,0,1 repeatedly -> char_data stable while char_valid && !char_ready. No byte lost or duplicated; full 192-byte stream matches the first test.
- Assert rst_n=0 for 1 cycle during EMIT of line 3, byte 10 -> all outputs 0 immediately. Subsequent start replays from line 0, byte 0.
- Pulse start again at byte 5 of line 0 -> ignored. Stream and done timing identical to the first test.
- Latency check: start at edge E0 -> mem_rd_en=1 with mem_addr=0 after E0; char_valid first high after E3.

Source files
------------

// File: rtl/decode_sequencer.sv
// Walks a stored encoded message line by line through the combinational line decoder
// and streams each recovered line out one ASCII byte per valid/ready handshake, MSB byte first.
module decode_sequencer #(
    parameter int NUM_MESSAGES = 8,
    parameter int ADDR_W       = 3,
    parameter int LINE_W       = 192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [LINE_W-1:0] dec_in,
    input  logic [LINE_W-1:0] dec_out,
    output logic              char_valid,
    output logic [7:0]        char_data,
    output logic              char_last,
    input  logic              char_ready
);

    localparam int NBYTES = LINE_W / 8;
    localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(NUM_MESSAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LATCH,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   line_idx;
    logic [BCNT_W-1:0]   byte_cnt;
    logic [LINE_W-1:0]   line_buf;
    logic                hs;
    logic                byte_last;
    logic                line_last;

    assign hs        = char_valid && char_ready;
    assign byte_last = (byte_cnt == LAST_BYTE);
    assign line_last = (line_idx == LAST_LINE);

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign mem_rd_en = (state == S_FETCH);
    assign mem_addr  = line_idx;
    assign char_last = char_valid && line_last && byte_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_EMIT;
            S_EMIT: begin
                if (hs && byte_last) begin
                    state_nxt = line_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read data lands in dec_in one cycle after the strobe; the decoder output is
    // captured only after dec_in has been stable for a whole cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_idx   <= '0;
            byte_cnt   <= '0;
            line_buf   <= '0;
            dec_in     <= '0;
            char_valid <= 1'b0;
            char_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) line_idx <= '0;
                end
                S_WAIT: begin
                    dec_in <= mem_rdata;
                end
                S_LATCH: begin
                    line_buf   <= dec_out;
                    byte_cnt   <= '0;
                    char_valid <= 1'b1;
                    char_data  <= dec_out[LINE_W-1 -: 8];
                end
                S_EMIT: begin
                    if (hs) begin
                        line_buf <= line_buf << 8;
                        byte_cnt <= byte_cnt + BCNT_W'(1);
                        if (byte_last) begin
                            char_valid <= 1'b0;
                            char_data  <= '0;
                            if (!line_last) line_idx <= line_idx + ADDR_W'(1);
                        end else begin
                            char_data <= line_buf[LINE_W-9 -: 8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
